cache_fill_arbiter: RTL

Shares the single multi-cycle main memory between the instruction-cache and data-cache miss handlers of the pipelined 16-bit CPU. It sequences 8-word block fills on cache misses and single-word write-through stores from the data cache. It sits between the two caches and the `memory4c`-style main memory. Each fill word is returned to the requesting cache with its word index.

---
 rtl/cpu_mem_pkg.sv | 25 ++
 rtl/mem_arb_grant.sv | 57 +++++
 rtl/cache_fill_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared types and constants for the cache fill arbiter
//
// Purpose: arbiter state enum, requester id enum, block geometry and memory latency.
// Ports: none (package).

package cpu_mem_pkg;

  localparam int unsigned WORDS_PER_BLK = 8;
  localparam int unsigned MEM_LAT       = 4;
  // Byte-offset bits within a block (2 bytes per word).
  localparam int unsigned BLK_OFF_MASK  = 2 * WORDS_PER_BLK - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - request-to-grant picker for the cache fill arbiter
//
// Purpose: writes always win; misses are fixed priority (D over I) by default, or
//   round-robin between D and I when ARB_RR_EN is defined.
// Ports:
//   clk, rst_n, upd_en - only with ARB_RR_EN; upd_en qualifies last-grant updates
//   wr_req, d_miss, i_miss - raw request levels
//   gnt_wr, gnt_miss, gnt_id - combinational grant decision

module mem_arb_grant
  import cpu_mem_pkg::*;
(
`ifdef ARB_RR_EN
  input  logic    clk,
  input  logic    rst_n,
  input  logic    upd_en,
`endif
  input  logic    wr_req,
  input  logic    d_miss,
  input  logic    i_miss,
  output logic    gnt_wr,
  output logic    gnt_miss,
  output req_id_e gnt_id
);

`ifdef ARB_RR_EN
  req_id_e last_q, last_d;

  // Remember the last miss winner so the other side is favoured on a tie.
  always_comb begin
    last_d = last_q;
    if (upd_en && gnt_miss) last_d = gnt_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= REQ_I;
    else        last_q <= last_d;
  end
`endif

  always_comb begin
    gnt_wr   = wr_req;
    gnt_miss = 1'b0;
    gnt_id   = REQ_I;
    if (!wr_req && (d_miss || i_miss)) begin
      gnt_miss = 1'b1;
`ifdef ARB_RR_EN
      if (d_miss && i_miss) gnt_id = (last_q == REQ_I) ? REQ_D : REQ_I;
      else                  gnt_id = d_miss ? REQ_D : REQ_I;
`else
      // Fixed priority: a steady stream of D misses can starve the I side.
      gnt_id = d_miss ? REQ_D : REQ_I;
`endif
    end
  end

endmodule

// File: rtl/cache_fill_arbiter.sv
// rtl/cache_fill_arbiter.sv - shares main memory between I/D cache fills and D writes
//
// Purpose: sequences 8-word block fills for I/D misses and single-word write-through
//   stores onto a fixed-latency memory. Optional macro ARB_RR_EN selects round-robin
//   between D and I misses (default: fixed D over I).
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   i_miss, i_miss_addr        - I-cache miss level and byte address
//   i_fill_valid/word/data/done, i_busy - I-cache fill return and status
//   d_miss, d_miss_addr, d_fill_*, d_busy - D-cache equivalents
//   d_wr_req, d_wr_addr, d_wr_data, d_wr_ack - write-through request / issue pulse
//   mem_en, mem_wr, mem_addr, mem_data_out - registered memory command
//   mem_data_in, mem_data_valid           - memory read return

module cache_fill_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  output logic              i_fill_valid,
  output logic [2:0]        i_fill_word,
  output logic [DATA_W-1:0] i_fill_data,
  output logic              i_fill_done,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  output logic              d_fill_valid,
  output logic [2:0]        d_fill_word,
  output logic [DATA_W-1:0] d_fill_data,
  output logic              d_fill_done,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              d_wr_ack,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_data_valid,
  output logic              i_busy,
  output logic              d_busy
);

  localparam logic [2:0]        LAST_WORD = 3'(WORDS_PER_BLK - 1);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(BLK_OFF_MASK);

  arb_state_e        state_q, state_d;
  req_id_e           id_q, id_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        iss_q, iss_d;
  logic [2:0]        ret_q, ret_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;

  logic              fill_valid, fill_done;
  logic              gnt_wr, gnt_miss;
  req_id_e           gnt_id;
  logic [ADDR_W-1:0] miss_base;
  logic [3:0]        iss_off;

  mem_arb_grant u_grant (
`ifdef ARB_RR_EN
    .clk      (clk),
    .rst_n    (rst_n),
    .upd_en   (state_q == IDLE),
`endif
    .wr_req   (d_wr_req),
    .d_miss   (d_miss),
    .i_miss   (i_miss),
    .gnt_wr   (gnt_wr),
    .gnt_miss (gnt_miss),
    .gnt_id   (gnt_id)
  );

  assign miss_base = ((gnt_id == REQ_D) ? d_miss_addr : i_miss_addr) & BASE_MASK;
  // Byte offset of the next read: word index of the following issue times 2.
  assign iss_off   = {iss_q + 3'd1, 1'b0};

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    base_d     = base_q;
    iss_d      = iss_q;
    ret_d      = ret_q;
    mem_en_d   = 1'b0;
    mem_wr_d   = 1'b0;
    mem_addr_d = '0;
    mem_data_d = '0;
    fill_valid = 1'b0;
    fill_done  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (gnt_wr) begin
          state_d    = WRITE;
          mem_en_d   = 1'b1;
          mem_wr_d   = 1'b1;
          mem_addr_d = d_wr_addr;
          mem_data_d = d_wr_data;
        end else if (gnt_miss) begin
          // Word 0 goes out on the FILL entry cycle, so it is launched from here.
          state_d    = FILL;
          id_d       = gnt_id;
          base_d     = miss_base;
          iss_d      = '0;
          ret_d      = '0;
          mem_en_d   = 1'b1;
          mem_addr_d = miss_base;
        end
      end

      WRITE: state_d = IDLE;

      FILL: begin
        // mem_en_q doubles as "issue still running"; it drops after the last word.
        if (mem_en_q) begin
          iss_d = iss_q + 3'd1;
          if (iss_q != LAST_WORD) begin
            mem_en_d   = 1'b1;
            mem_addr_d = base_q + ADDR_W'(iss_off);
          end
        end
        if (mem_data_valid) begin
          fill_valid = 1'b1;
          ret_d      = ret_q + 3'd1;
          if (ret_q == LAST_WORD) begin
            fill_done = 1'b1;
            state_d   = DONE;
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      id_q       <= REQ_I;
      base_q     <= '0;
      iss_q      <= '0;
      ret_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      base_q     <= base_d;
      iss_q      <= iss_d;
      ret_q      <= ret_d;
      mem_en_q   <= mem_en_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign mem_en       = mem_en_q;
  assign mem_wr       = mem_wr_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data_out = mem_data_q;
  assign d_wr_ack     = (state_q == WRITE);

  // Fill returns go only to the granted side; the other side is held at 0.
  assign i_fill_valid = fill_valid && (id_q == REQ_I);
  assign d_fill_valid = fill_valid && (id_q == REQ_D);
  assign i_fill_done  = fill_done && (id_q == REQ_I);
  assign d_fill_done  = fill_done && (id_q == REQ_D);
  assign i_fill_word  = i_fill_valid ? ret_q : 3'd0;
  assign d_fill_word  = d_fill_valid ? ret_q : 3'd0;
  assign i_fill_data  = i_fill_valid ? mem_data_in : '0;
  assign d_fill_data  = d_fill_valid ? mem_data_in : '0;
  assign i_busy       = (state_q == FILL) && (id_q == REQ_I);
  assign d_busy       = (state_q == FILL) && (id_q == REQ_D);

endmodule
